// File: rtl/nios_system_irq_ctrl_pkg.sv
// Shared register-map constants for the nios_system_irq_ctrl interrupt aggregator.
// Imported by the top module and the priority encoder.
package nios_system_irq_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_PENDING  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_MODE     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_RAW      = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OVERFLOW = 3'd5;

  localparam int ACTIVE_VALID_BIT = 15;

endpackage

// File: rtl/nios_system_irq_ctrl_prio_enc.sv
// Combinational lowest-index-first priority encoder for the ACTIVE register.
// o_valid is high when any request bit is set; o_idx is then the lowest set bit.
module nios_system_irq_ctrl_prio_enc
  import nios_system_irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int IDX_W   = 4
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  // Scan from the top down so the lowest-numbered request is the last to win.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/nios_system_irq_ctrl.sv
// Avalon-MM interrupt aggregator: sticky pending bits, mask, edge/level mode, overflow.
// Optional macro IRQ_CTRL_SYNC_EN adds a 2-flop synchroniser on every irq_in bit.
module nios_system_irq_ctrl
  import nios_system_irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int IDX_W   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [DATA_W-1:0]   writedata,
  input  logic [NUM_SRC-1:0]  irq_in,
  output logic [DATA_W-1:0]   readdata,
  output logic                irq
);

  // Bus handshake: zero wait states. A write is accepted on every clk edge where
  // chipselect && !write_n; readdata always shows the register selected by
  // address in the previous cycle, and reads never change state.

  logic [NUM_SRC-1:0] w_in;
  logic [NUM_SRC-1:0] w_event;
  logic [NUM_SRC-1:0] w_wdata;
  logic [NUM_SRC-1:0] w_w1c_pend;
  logic [NUM_SRC-1:0] w_w1c_ovf;
  logic [NUM_SRC-1:0] w_pend_nxt;
  logic [NUM_SRC-1:0] w_ovf_nxt;
  logic [NUM_SRC-1:0] w_enabled;
  logic               w_wr;
  logic               w_act_valid;
  logic [IDX_W-1:0]   w_act_idx;
  logic [DATA_W-1:0]  w_active;
  logic [DATA_W-1:0]  w_rd_mux;
  logic               w_unused_wdata;

  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_mode;
  logic [NUM_SRC-1:0] r_overflow;
  logic [NUM_SRC-1:0] r_prev;
  logic [DATA_W-1:0]  r_readdata;
  logic               r_irq;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_in = r_sync2;
`else
  assign w_in = irq_in;
`endif

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[NUM_SRC-1:0];
  assign w_unused_wdata = ^writedata[DATA_W-1:NUM_SRC];

  assign w_w1c_pend = (w_wr && (address == ADDR_PENDING))  ? w_wdata : '0;
  assign w_w1c_ovf  = (w_wr && (address == ADDR_OVERFLOW)) ? w_wdata : '0;

  // prev follows the input in both modes, so a later switch to edge mode
  // while the input is already high does not look like a fresh edge.
  assign w_event    = (r_mode & w_in & ~r_prev) | (~r_mode & w_in);
  assign w_pend_nxt = w_event | (r_pending & ~w_w1c_pend);
  assign w_ovf_nxt  = (w_event & r_mode & r_pending & ~w_w1c_pend)
                    | (r_overflow & ~w_w1c_ovf);
  assign w_enabled  = r_pending & r_mask;

  nios_system_irq_ctrl_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .i_req   (w_enabled),
    .o_valid (w_act_valid),
    .o_idx   (w_act_idx)
  );

  always_comb begin
    w_active = '0;
    if (w_act_valid) begin
      w_active[ACTIVE_VALID_BIT] = 1'b1;
      w_active[IDX_W-1:0]        = w_act_idx;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_PENDING:  w_rd_mux = DATA_W'(r_pending);
      ADDR_MASK:     w_rd_mux = DATA_W'(r_mask);
      ADDR_MODE:     w_rd_mux = DATA_W'(r_mode);
      ADDR_ACTIVE:   w_rd_mux = w_active;
      ADDR_RAW:      w_rd_mux = DATA_W'(w_in);
      ADDR_OVERFLOW: w_rd_mux = DATA_W'(r_overflow);
      default:       w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending  <= '0;
      r_mask     <= '0;
      r_mode     <= '0;
      r_overflow <= '0;
      r_prev     <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_prev     <= w_in;
      r_pending  <= w_pend_nxt;
      r_overflow <= w_ovf_nxt;
      if (w_wr && (address == ADDR_MASK)) begin
        r_mask <= w_wdata;
      end
      if (w_wr && (address == ADDR_MODE)) begin
        r_mode <= w_wdata;
      end
      r_readdata <= w_rd_mux;
      r_irq      <= |w_enabled;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_nios_system_irq_ctrl.sv
// Self-checking bench for nios_system_irq_ctrl: behavioural model plus directed and
// random stimulus. Honours IRQ_CTRL_SYNC_EN for the expected input latency.
module tb_nios_system_irq_ctrl;
  import nios_system_irq_ctrl_pkg::*;

  localparam int NUM_SRC = 8;
  localparam int IDX_W   = 4;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int IRQ_LAT = SYNC + 2;

  // ---------------- clock / reset ----------------
  logic               clk        = 1'b0;
  logic               reset_n    = 1'b1;
  logic [2:0]         address    = '0;
  logic               chipselect = 1'b0;
  logic               write_n    = 1'b1;
  logic [15:0]        writedata  = '0;
  logic [NUM_SRC-1:0] irq_in     = '0;
  logic [15:0]        readdata;
  logic               irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios_system_irq_ctrl #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .irq_in     (irq_in),
    .readdata   (readdata),
    .irq        (irq)
  );

  function automatic void chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, got, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [NUM_SRC-1:0] m_pend = '0, m_mask = '0, m_mode = '0, m_ovf = '0, m_last = '0;
  logic [15:0]        m_rd   = '0;
  logic               m_irq  = 1'b0;
  logic [NUM_SRC-1:0] in_q[$];

  function automatic logic [15:0] model_read(input logic [2:0] a, input logic [NUM_SRC-1:0] raw);
    case (a)
      3'd0: return 16'(m_pend);
      3'd1: return 16'(m_mask);
      3'd2: return 16'(m_mode);
      3'd3: begin
        for (int i = 0; i < NUM_SRC; i++)
          if (m_pend[i] && m_mask[i]) return 16'h8000 | 16'(i);
        return 16'h0000;
      end
      3'd4: return 16'(raw);
      3'd5: return 16'(m_ovf);
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = '0; m_mask = '0; m_mode = '0; m_ovf = '0; m_last = '0;
      m_rd   = '0; m_irq  = 1'b0;
      in_q.delete();
      for (int i = 0; i < SYNC; i++) in_q.push_back('0);
    end else begin
      logic [NUM_SRC-1:0] raw, nxt_pend, nxt_ovf;
      bit wr;
      // The input seen by the capture logic is irq_in delayed by SYNC cycles.
      in_q.push_back(irq_in);
      raw   = in_q.pop_front();
      m_rd  = model_read(address, raw);
      m_irq = |(m_pend & m_mask);
      wr    = chipselect && !write_n;
      for (int i = 0; i < NUM_SRC; i++) begin
        bit ev, clr_p, clr_o;
        ev    = raw[i] && (!m_mode[i] || !m_last[i]);
        clr_p = wr && (address == ADDR_PENDING)  && writedata[i];
        clr_o = wr && (address == ADDR_OVERFLOW) && writedata[i];
        nxt_pend[i] = ev || (m_pend[i] && !clr_p);
        nxt_ovf[i]  = (ev && m_mode[i] && m_pend[i] && !clr_p) || (m_ovf[i] && !clr_o);
      end
      m_pend = nxt_pend;
      m_ovf  = nxt_ovf;
      m_last = raw;
      if (wr && address == ADDR_MASK) m_mask = writedata[NUM_SRC-1:0];
      if (wr && address == ADDR_MODE) m_mode = writedata[NUM_SRC-1:0];
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    chk("cyc_readdata", readdata, m_rd);
    chk("cyc_irq", 16'(irq), 16'(m_irq));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
    chk(name, readdata, exp);
    chk({name, "_model"}, m_rd, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Reset values
    for (int a = 0; a < 8; a++) bus_rd(3'(a), 16'h0000, "reset_read");
    chk("reset_irq", 16'(irq), 16'h0000);

    // Edge pulse on source 0, irq latency, and W1C
    bus_wr(ADDR_MODE, 16'h0001);
    bus_wr(ADDR_MASK, 16'h0001);
    irq_in[0] = 1'b1;
    tick();
    irq_in[0] = 1'b0;
    tick(IRQ_LAT - 2);
    chk("irq_before_lat", 16'(irq), 16'h0000);
    tick();
    chk("irq_at_lat", 16'(irq), 16'h0001);
    bus_rd(ADDR_PENDING, 16'h0001, "pend_edge0");
    bus_wr(ADDR_PENDING, 16'h0001);
    chk("irq_clear_edge", 16'(irq), 16'h0001);
    tick();
    chk("irq_after_clear", 16'(irq), 16'h0000);

    // Level mode re-set while held, then clear after release
    bus_wr(ADDR_MODE, 16'h0000);
    bus_wr(ADDR_MASK, 16'h0004);
    irq_in[2] = 1'b1;
    tick(SYNC + 2);
    bus_wr(ADDR_PENDING, 16'h0004);
    bus_rd(ADDR_PENDING, 16'h0004, "pend_level_reset");
    irq_in[2] = 1'b0;
    tick(SYNC + 1);
    bus_wr(ADDR_PENDING, 16'h0004);
    bus_rd(ADDR_PENDING, 16'h0000, "pend_level_clear");

    // Overflow on source 3
    bus_wr(ADDR_MODE, 16'h0008);
    irq_in[3] = 1'b1; tick();
    irq_in[3] = 1'b0; tick();
    irq_in[3] = 1'b1; tick();
    irq_in[3] = 1'b0; tick(SYNC + 1);
    bus_rd(ADDR_OVERFLOW, 16'h0008, "ovf_set");
    bus_wr(ADDR_OVERFLOW, 16'h0008);
    bus_rd(ADDR_OVERFLOW, 16'h0000, "ovf_clear");

    // ACTIVE priority encoding
    bus_wr(ADDR_PENDING, 16'h00FF);
    bus_wr(ADDR_MASK, 16'h00FF);
    bus_wr(ADDR_MODE, 16'h0024);
    irq_in[2] = 1'b1; irq_in[5] = 1'b1; tick();
    irq_in[2] = 1'b0; irq_in[5] = 1'b0; tick(SYNC + 1);
    bus_rd(ADDR_ACTIVE, 16'h8002, "active_2");
    bus_wr(ADDR_PENDING, 16'h0004);
    bus_rd(ADDR_ACTIVE, 16'h8005, "active_5");
    bus_wr(ADDR_PENDING, 16'h0020);
    bus_rd(ADDR_ACTIVE, 16'h0000, "active_none");

    // Set wins over same-cycle W1C on source 1
    bus_wr(ADDR_MODE, 16'h0002);
    irq_in[1] = 1'b1; tick();
    irq_in[1] = 1'b0; tick(SYNC + 1);
    bus_rd(ADDR_PENDING, 16'h0002, "pend_src1");
    irq_in[1] = 1'b1;
    tick(SYNC);
    bus_wr(ADDR_PENDING, 16'h0002);
    irq_in[1] = 1'b0;
    bus_rd(ADDR_PENDING, 16'h0002, "set_wins");
    bus_rd(ADDR_OVERFLOW, 16'h0000, "no_ovf_on_clear");

    // Input-to-irq latency measurement
    bus_wr(ADDR_PENDING, 16'h00FF);
    bus_wr(ADDR_MASK, 16'h0010);
    bus_wr(ADDR_MODE, 16'h0010);
    tick(3);
    irq_in[4] = 1'b1;
    cnt = 0;
    while (!irq && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("irq_latency", 16'(cnt), 16'(IRQ_LAT));

    // Asynchronous reset with irq asserted
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_irq", 16'(irq), 16'h0000);
    chk("async_rst_rd", readdata, 16'h0000);
    tick(2);
    irq_in = '0;
    reset_n = 1'b1;
    tick(SYNC + 1);
    bus_rd(ADDR_PENDING, 16'h0000, "pend_after_rst");

    // Randomised traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = NUM_SRC'($urandom);
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = 16'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end else begin
        tick();
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
